// File: rtl/tea_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tea_pkg
//  Purpose  : Shared types, constants and helpers for the TEA cipher engine.
//             Word, key and block typedefs, the FSM state enum, the default
//             key-schedule constant and the decrypt initial-sum helper.
//  Revision : 1.0  initial release
// ============================================================================
package tea_pkg;

    // Default key-schedule constant (golden-ratio derived).
    localparam logic [31:0] c_DELTA_DEFAULT = 32'h9E3779B9;

    typedef logic [31:0] tea_word_t;

    // Word [3] is k0 (key bits [127:96]); word [0] is k3.
    typedef tea_word_t [3:0] tea_key_t;

    // Word [1] is v0 (block bits [63:32]); word [0] is v1.
    typedef tea_word_t [1:0] tea_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_e;

    // Starting sum for decryption: DELTA accumulated over every cycle,
    // truncated to 32 bits.
    function automatic tea_word_t tea_decrypt_sum(input tea_word_t   delta,
                                                  input int unsigned num_cycles);
        return delta * tea_word_t'(num_cycles);
    endfunction

    // Select key word kN by its logical index (0 = most significant word).
    function automatic tea_word_t tea_key_word(input tea_key_t   key,
                                               input logic [1:0] idx);
        return key[2'd3 - idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tea_round.sv
`default_nettype none
// ============================================================================
//  Module   : tea_round
//  Purpose  : One combinational TEA cycle (Feistel round pair), encrypt or
//             decrypt. With TEA_XTEA_EN defined, an XTEA cycle is selectable.
//  Ports    : i_decrypt  0 = encrypt, 1 = decrypt
//             i_xtea     (TEA_XTEA_EN only) 1 = XTEA cycle
//             i_key      128-bit key, k0 in the top word
//             i_v0/i_v1  block halves entering the cycle
//             i_sum      running key-schedule sum entering the cycle
//             o_v0/o_v1  block halves leaving the cycle
//             o_sum      key-schedule sum leaving the cycle
//  Revision : 1.0  initial release
// ============================================================================
module tea_round
    import tea_pkg::*;
#(
    parameter tea_word_t DELTA = c_DELTA_DEFAULT
) (
    input  logic      i_decrypt,
`ifdef TEA_XTEA_EN
    input  logic      i_xtea,
`endif
    input  tea_key_t  i_key,
    input  tea_word_t i_v0,
    input  tea_word_t i_v1,
    input  tea_word_t i_sum,
    output tea_word_t o_v0,
    output tea_word_t o_v1,
    output tea_word_t o_sum
);

    // TEA half-round mixing term.
    function automatic tea_word_t tea_f(input tea_word_t v, input tea_word_t s,
                                        input tea_word_t ka, input tea_word_t kb);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

`ifdef TEA_XTEA_EN
    // XTEA data-dependent mixing term (key term added separately).
    function automatic tea_word_t xtea_mix(input tea_word_t v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction
`endif

    tea_word_t w_k0, w_k1, w_k2, w_k3;
    tea_word_t w_v0, w_v1, w_sum;

    assign w_k0 = tea_key_word(i_key, 2'd0);
    assign w_k1 = tea_key_word(i_key, 2'd1);
    assign w_k2 = tea_key_word(i_key, 2'd2);
    assign w_k3 = tea_key_word(i_key, 2'd3);

    // Second half of each cycle consumes the freshly updated first half,
    // so w_v0/w_v1 are read back within the same block on purpose.
    always_comb begin
        w_v0  = i_v0;
        w_v1  = i_v1;
        w_sum = i_sum;
`ifdef TEA_XTEA_EN
        if (i_xtea) begin
            if (!i_decrypt) begin
                w_v0  = i_v0 + (xtea_mix(i_v1) ^ (i_sum + tea_key_word(i_key, i_sum[1:0])));
                w_sum = i_sum + DELTA;
                w_v1  = i_v1 + (xtea_mix(w_v0) ^ (w_sum + tea_key_word(i_key, w_sum[12:11])));
            end else begin
                w_v1  = i_v1 - (xtea_mix(i_v0) ^ (i_sum + tea_key_word(i_key, i_sum[12:11])));
                w_sum = i_sum - DELTA;
                w_v0  = i_v0 - (xtea_mix(w_v1) ^ (w_sum + tea_key_word(i_key, w_sum[1:0])));
            end
        end else
`endif
        if (!i_decrypt) begin
            // Encrypt advances the sum before mixing.
            w_sum = i_sum + DELTA;
            w_v0  = i_v0 + tea_f(i_v1, w_sum, w_k0, w_k1);
            w_v1  = i_v1 + tea_f(w_v0, w_sum, w_k2, w_k3);
        end else begin
            // Decrypt mixes with the current sum, then retreats it.
            w_v1  = i_v1 - tea_f(i_v0, i_sum, w_k2, w_k3);
            w_v0  = i_v0 - tea_f(w_v1, i_sum, w_k0, w_k1);
            w_sum = i_sum - DELTA;
        end
    end

    assign o_v0  = w_v0;
    assign o_v1  = w_v1;
    assign o_sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/tea_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module   : tea_cipher_core
//  Purpose  : Iterative TEA block-cipher engine with encrypt/decrypt, a
//             configurable cycle count, configurable unrolling and
//             valid/ready handshakes on input and output.
//             Optional XTEA mode is compiled in when TEA_XTEA_EN is defined.
//  Ports    : i_clk, i_rst_n      clock, asynchronous active-low reset
//             i_valid / o_ready   input handshake (accept = i_valid & o_ready)
//             i_decrypt           mode, sampled on accept
//             i_xtea              (TEA_XTEA_EN only) XTEA select, sampled on accept
//             i_key [127:0]       k0..k3 from MSB to LSB, sampled on accept
//             i_block [63:0]      v0 = [63:32], v1 = [31:0], sampled on accept
//             i_clear             synchronous abort back to IDLE
//             o_valid / i_ready   output handshake
//             o_block [63:0]      result, same packing as i_block
//             o_busy              high while running or holding a result
//  Revision : 1.0  initial release
// ============================================================================
module tea_cipher_core
    import tea_pkg::*;
#(
    parameter int unsigned NUM_CYCLES     = 32,
    parameter int unsigned CYCLES_PER_CLK = 1,
    parameter tea_word_t   DELTA          = c_DELTA_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_decrypt,
`ifdef TEA_XTEA_EN
    input  logic          i_xtea,
`endif
    input  logic [127:0]  i_key,
    input  logic [63:0]   i_block,
    input  logic          i_clear,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [63:0]   o_block,
    output logic          o_busy
);

    localparam int unsigned c_ITERS   = NUM_CYCLES / CYCLES_PER_CLK;
    localparam int unsigned c_CNT_W   = $clog2(c_ITERS + 1);
    localparam tea_word_t   c_DEC_SUM = tea_decrypt_sum(DELTA, NUM_CYCLES);

    tea_state_e         r_state;
    tea_word_t          r_v0, r_v1, r_sum;
    tea_key_t           r_key;
    logic               r_decrypt;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ready, r_valid, r_busy;
    tea_block_t         r_block;
`ifdef TEA_XTEA_EN
    logic               r_xtea;
`endif

    // Unrolled round chain: stage 0 is the register contents, stage
    // CYCLES_PER_CLK is the value written back at the next edge.
    tea_word_t w_v0  [CYCLES_PER_CLK:0];
    tea_word_t w_v1  [CYCLES_PER_CLK:0];
    tea_word_t w_sum [CYCLES_PER_CLK:0];

    assign w_v0[0]  = r_v0;
    assign w_v1[0]  = r_v1;
    assign w_sum[0] = r_sum;

    generate
        for (genvar gi = 0; gi < CYCLES_PER_CLK; gi++) begin : g_round
            tea_round #(
                .DELTA (DELTA)
            ) u_round (
                .i_decrypt (r_decrypt),
`ifdef TEA_XTEA_EN
                .i_xtea    (r_xtea),
`endif
                .i_key     (r_key),
                .i_v0      (w_v0[gi]),
                .i_v1      (w_v1[gi]),
                .i_sum     (w_sum[gi]),
                .o_v0      (w_v0[gi+1]),
                .o_v1      (w_v1[gi+1]),
                .o_sum     (w_sum[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_v0      <= '0;
            r_v1      <= '0;
            r_sum     <= '0;
            r_key     <= '0;
            r_decrypt <= 1'b0;
`ifdef TEA_XTEA_EN
            r_xtea    <= 1'b0;
`endif
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_block   <= '0;
        end else if (i_clear) begin
            // Abort wins over accept and handoff; last result stays visible.
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid && r_ready) begin
                        r_key     <= i_key;
                        r_v0      <= i_block[63:32];
                        r_v1      <= i_block[31:0];
                        r_decrypt <= i_decrypt;
`ifdef TEA_XTEA_EN
                        r_xtea    <= i_xtea;
`endif
                        r_sum     <= i_decrypt ? c_DEC_SUM : '0;
                        r_count   <= c_CNT_W'(c_ITERS);
                        r_state   <= RUN;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                RUN: begin
                    r_v0    <= w_v0[CYCLES_PER_CLK];
                    r_v1    <= w_v1[CYCLES_PER_CLK];
                    r_sum   <= w_sum[CYCLES_PER_CLK];
                    r_count <= r_count - 1'b1;
                    if (r_count == c_CNT_W'(1)) begin
                        r_block <= {w_v0[CYCLES_PER_CLK], w_v1[CYCLES_PER_CLK]};
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_block = r_block;

endmodule
`default_nettype wire

// File: tb/tb_tea_cipher_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tea_cipher_core
//  Purpose  : Self-checking bench for tea_cipher_core. Three instances share
//             data/control inputs and have private i_valid lines:
//               dut 0 : 32 cycles, 1 per clock
//               dut 1 : 32 cycles, 4 per clock
//               dut 2 : 16 cycles, 2 per clock
//             Results are compared with a loop-based reference cipher.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tea_cipher_core;

    localparam logic [31:0] c_DELTA = 32'h9E3779B9;
    localparam logic [63:0] c_KAT_TEA  = 64'h41EA3A0A_94BAA940;
    localparam logic [63:0] c_KAT_XTEA = 64'hDEE9D4D8_F7131ED9;

    logic         clk;
    logic         rst_n;
    logic [2:0]   valid_v;
    logic [2:0]   ready_v;
    logic [2:0]   ovalid_v;
    logic [2:0]   busy_v;
    logic [63:0]  oblock_v [3];
    logic         dec_in;
    logic [127:0] key_in;
    logic [63:0]  blk_in;
    logic         clear_in;
    logic         ready_in;
`ifdef TEA_XTEA_EN
    logic         xtea_in;
`endif

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tea_cipher_core #(.NUM_CYCLES(32), .CYCLES_PER_CLK(1), .DELTA(c_DELTA)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[0]), .o_ready(ready_v[0]),
        .i_decrypt(dec_in), .i_key(key_in), .i_block(blk_in), .i_clear(clear_in),
        .o_valid(ovalid_v[0]), .i_ready(ready_in), .o_block(oblock_v[0]), .o_busy(busy_v[0])
`ifdef TEA_XTEA_EN
        , .i_xtea(xtea_in)
`endif
    );

    tea_cipher_core #(.NUM_CYCLES(32), .CYCLES_PER_CLK(4), .DELTA(c_DELTA)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[1]), .o_ready(ready_v[1]),
        .i_decrypt(dec_in), .i_key(key_in), .i_block(blk_in), .i_clear(clear_in),
        .o_valid(ovalid_v[1]), .i_ready(ready_in), .o_block(oblock_v[1]), .o_busy(busy_v[1])
`ifdef TEA_XTEA_EN
        , .i_xtea(xtea_in)
`endif
    );

    tea_cipher_core #(.NUM_CYCLES(16), .CYCLES_PER_CLK(2), .DELTA(c_DELTA)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[2]), .o_ready(ready_v[2]),
        .i_decrypt(dec_in), .i_key(key_in), .i_block(blk_in), .i_clear(clear_in),
        .o_valid(ovalid_v[2]), .i_ready(ready_in), .o_block(oblock_v[2]), .o_busy(busy_v[2])
`ifdef TEA_XTEA_EN
        , .i_xtea(xtea_in)
`endif
    );

    function automatic int cycles_of(input int sel);
        return (sel == 2) ? 16 : 32;
    endfunction

    function automatic int latency_of(input int sel);
        return (sel == 0) ? 32 : 8;
    endfunction

    // Textbook TEA / XTEA, one loop iteration per cycle.
    function automatic logic [63:0] ref_cipher(input bit dec, input bit xt,
                                               input logic [127:0] key,
                                               input logic [63:0] blk, input int n);
        logic [31:0] k [4];
        logic [31:0] y, z, s;
        k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
        y = blk[63:32];
        z = blk[31:0];
        s = dec ? c_DELTA * 32'(n) : 32'd0;
        for (int i = 0; i < n; i++) begin
            if (!dec && !xt) begin
                s += c_DELTA;
                y += ((z << 4) + k[0]) ^ (z + s) ^ ((z >> 5) + k[1]);
                z += ((y << 4) + k[2]) ^ (y + s) ^ ((y >> 5) + k[3]);
            end else if (dec && !xt) begin
                z -= ((y << 4) + k[2]) ^ (y + s) ^ ((y >> 5) + k[3]);
                y -= ((z << 4) + k[0]) ^ (z + s) ^ ((z >> 5) + k[1]);
                s -= c_DELTA;
            end else if (!dec) begin
                y += (((z << 4) ^ (z >> 5)) + z) ^ (s + k[s[1:0]]);
                s += c_DELTA;
                z += (((y << 4) ^ (y >> 5)) + y) ^ (s + k[s[12:11]]);
            end else begin
                z -= (((y << 4) ^ (y >> 5)) + y) ^ (s + k[s[12:11]]);
                s -= c_DELTA;
                y -= (((z << 4) ^ (z >> 5)) + z) ^ (s + k[s[1:0]]);
            end
        end
        return {y, z};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction on dut 'sel' with i_ready held high. Entered and
    // left 1 time unit after a rising edge with the selected dut idle.
    // Inputs are scrambled right after accept.
    task automatic do_txn(input int sel, input bit dec, input logic [127:0] key,
                          input logic [63:0] blk, output logic [63:0] res, output int lat);
        dec_in = dec;
        key_in = key;
        blk_in = blk;
        valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        valid_v[sel] = 1'b0;
        key_in = rand_key();
        blk_in = {$urandom, $urandom};
        dec_in = ~dec;
        lat = 0;
        while (!ovalid_v[sel] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = oblock_v[sel];
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] k;
        logic [63:0]  b, r, r2, held, prev;
        int           lat, w;
        bit           flag;

        rst_n    = 1'b0;
        valid_v  = '0;
        dec_in   = 1'b0;
        key_in   = '0;
        blk_in   = '0;
        clear_in = 1'b0;
        ready_in = 1'b1;
`ifdef TEA_XTEA_EN
        xtea_in  = 1'b0;
`endif

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check("rst_ready", 64'(ready_v[s]), 64'd1);
            check("rst_valid", 64'(ovalid_v[s]), 64'd0);
            check("rst_busy",  64'(busy_v[s]), 64'd0);
            check("rst_block", oblock_v[s], 64'd0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- known vectors, dut 0 ----------------
        do_txn(0, 1'b0, '0, '0, r, lat);
        check("kat_enc", r, c_KAT_TEA);
        check("kat_enc_lat", 64'(lat), 64'd32);
        check("kat_idle_after", 64'(ready_v[0]), 64'd1);
        do_txn(0, 1'b1, '0, c_KAT_TEA, r, lat);
        check("kat_dec", r, 64'd0);
        check("kat_dec_lat", 64'(lat), 64'd32);

        // ---------------- random round trips, dut 0 ----------------
        for (int i = 0; i < 100; i++) begin
            k = rand_key();
            b = {$urandom, $urandom};
            do_txn(0, 1'b0, k, b, r, lat);
            check("rnd_enc", r, ref_cipher(1'b0, 1'b0, k, b, 32));
            do_txn(0, 1'b1, k, r, r2, lat);
            check("rnd_roundtrip", r2, b);
        end

        // ---------------- unrolled / short variants ----------------
        for (int s = 1; s < 3; s++) begin
            if (s == 1) begin
                do_txn(1, 1'b0, '0, '0, r, lat);
                check("u4_kat_enc", r, c_KAT_TEA);
                check("u4_kat_lat", 64'(lat), 64'd8);
                do_txn(1, 1'b1, '0, c_KAT_TEA, r, lat);
                check("u4_kat_dec", r, 64'd0);
            end
            for (int i = 0; i < 10; i++) begin
                k = rand_key();
                b = {$urandom, $urandom};
                do_txn(s, 1'b0, k, b, r, lat);
                check("var_enc", r, ref_cipher(1'b0, 1'b0, k, b, cycles_of(s)));
                check("var_lat", 64'(lat), 64'(latency_of(s)));
                do_txn(s, 1'b1, k, r, r2, lat);
                check("var_roundtrip", r2, b);
            end
        end

        // ---------------- result held while i_ready low ----------------
        ready_in = 1'b0;
        k = rand_key();
        b = {$urandom, $urandom};
        dec_in = 1'b0; key_in = k; blk_in = b;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        check("run_ready_low", 64'(ready_v[0]), 64'd0);
        check("run_busy", 64'(busy_v[0]), 64'd1);
        w = 0;
        while (!ovalid_v[0] && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("hold_lat", 64'(w), 64'd32);
        held = oblock_v[0];
        check("hold_result", held, ref_cipher(1'b0, 1'b0, k, b, 32));
        blk_in = {$urandom, $urandom};
        valid_v[0] = 1'b1;
        flag = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (oblock_v[0] !== held || ready_v[0] !== 1'b0 || ovalid_v[0] !== 1'b1)
                flag = 1'b0;
        end
        check("hold_stable", 64'(flag), 64'd1);
        valid_v[0] = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        check("release_ready", 64'(ready_v[0]), 64'd1);
        check("release_valid", 64'(ovalid_v[0]), 64'd0);
        check("release_no_accept", 64'(busy_v[0]), 64'd0);

        // ---------------- synchronous clear mid-run ----------------
        prev = oblock_v[0];
        dec_in = 1'b0; key_in = rand_key(); blk_in = {$urandom, $urandom};
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        clear_in = 1'b1;
        @(posedge clk); #1;
        clear_in = 1'b0;
        check("clr_ready", 64'(ready_v[0]), 64'd1);
        check("clr_busy", 64'(busy_v[0]), 64'd0);
        check("clr_valid", 64'(ovalid_v[0]), 64'd0);
        check("clr_block_kept", oblock_v[0], prev);
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ovalid_v[0] !== 1'b0) flag = 1'b1;
        end
        check("clr_no_valid", 64'(flag), 64'd0);

        // ---------------- asynchronous reset mid-run ----------------
        do_txn(0, 1'b0, '0, '0, r, lat);
        check("pre_rst_kat", r, c_KAT_TEA);
        dec_in = 1'b0; key_in = rand_key(); blk_in = {$urandom, $urandom};
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(ready_v[0]), 64'd1);
        check("arst_valid", 64'(ovalid_v[0]), 64'd0);
        check("arst_busy", 64'(busy_v[0]), 64'd0);
        check("arst_block", oblock_v[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ovalid_v[0] !== 1'b0) flag = 1'b1;
        end
        check("arst_no_valid", 64'(flag), 64'd0);
        do_txn(0, 1'b0, '0, '0, r, lat);
        check("post_rst_kat", r, c_KAT_TEA);

`ifdef TEA_XTEA_EN
        // ---------------- XTEA mode ----------------
        xtea_in = 1'b1;
        do_txn(0, 1'b0, '0, '0, r, lat);
        check("xtea_kat_enc", r, c_KAT_XTEA);
        do_txn(0, 1'b1, '0, c_KAT_XTEA, r, lat);
        check("xtea_kat_dec", r, 64'd0);
        for (int i = 0; i < 10; i++) begin
            k = rand_key();
            b = {$urandom, $urandom};
            do_txn(0, 1'b0, k, b, r, lat);
            check("xtea_enc", r, ref_cipher(1'b0, 1'b1, k, b, 32));
            do_txn(0, 1'b1, k, r, r2, lat);
            check("xtea_roundtrip", r2, b);
        end
        xtea_in = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tea_cipher_core.md
Name: tea_cipher_core

Overview:
- Parametrised, iterative TEA block-cipher engine. Successor to the fixed-function encrypt datapath: adds decrypt mode, a configurable cycle count, configurable unrolling and valid/ready handshakes on both sides.
- Sits between the byte frontend/key store and the UART return path.
- Accepts one 64-bit block plus a 128-bit key per transaction and returns one 64-bit result.

Parameters:
- NUM_CYCLES, 32, number of TEA cycles (Feistel round pairs); power of two, 1..64.
- CYCLES_PER_CLK, 1, cycles unrolled per clock; 1, 2 or 4; must divide NUM_CYCLES.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input transaction valid
- o_ready  out  1  core can accept a transaction
- i_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- i_key  in  128  k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0]; sampled on accept
- i_block  in  64  v0 = [63:32], v1 = [31:0]; sampled on accept
- i_clear  in  1  synchronous abort
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_block  out  64  result, same packing as i_block
- o_busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: state IDLE, o_ready = 1, o_valid = 0, o_busy = 0, o_block = 0. Internal v0, v1, sum, key and counter registers are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready = 1.
  - Accept occurs when i_valid & o_ready. On accept, latch key, v0, v1 and mode, and set the counter to NUM_CYCLES/CYCLES_PER_CLK.
  - sum is loaded with 0 for encrypt, or (DELTA*NUM_CYCLES) mod 2^32 for decrypt.
  - Next state is RUN.
- RUN:
  - Each clock applies CYCLES_PER_CLK cycles combinationally and decrements the counter.
  - When the counter reaches 1 on a clock edge, the final result is registered into o_block and the FSM enters DONE.
  - Latency: o_valid rises exactly NUM_CYCLES/CYCLES_PER_CLK clocks after the accept edge (32 for defaults).
- Encrypt cycle:
  - sum += DELTA
  - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)
  - v1 += ((v0'<<4)+k2) ^ (v0'+sum) ^ ((v0'>>5)+k3), where v0' is the updated v0.
- Decrypt cycle:
  - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
  - v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1), where v1' is the updated v1.
  - sum -= DELTA
- Arithmetic: all operations are 32-bit modulo 2^32. Shifts are logical.
- DONE:
  - o_valid = 1 and o_block is stable.
  - On i_valid... more precisely, on o_valid & i_ready, go to IDLE and drop o_valid the next clock.
  - No accept occurs in the same clock (o_ready = 0 in RUN and DONE).
  - Holding i_ready low holds the result indefinitely.
- i_clear: in any state, forces IDLE next clock, o_valid = 0, and leaves o_block unchanged. It has priority over accept and over result handoff.
- Async reset mid-RUN: immediately returns to reset values. A partially computed result is never output.
- Inputs i_key, i_block and i_decrypt may change freely after accept without affecting the result.

Optional Feature:
- Macro: TEA_XTEA_EN.
- When defined:
  - Adds input port i_xtea (1 bit), sampled on accept.
  - When i_xtea is set, XTEA rounds are used:
    - v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum + k[sum&3])
    - sum += DELTA
    - v1 += (((v0<<4)^(v0>>5))+v0) ^ (sum + k[(sum>>11)&3])
  - Decrypt is the mirrored inverse.
  - Key index 0 selects k0 = i_key[127:96].
- When undefined: the port is absent and only TEA is used.

Decomposition:
- Package tea_pkg holds:
  - the DELTA default
  - typedef tea_word_t (32-bit)
  - typedef tea_key_t (4 x tea_word_t)
  - typedef tea_block_t (2 x tea_word_t)
  - enum tea_state_e {IDLE, RUN, DONE}
  - functions for the decrypt initial sum
- One sub-module: tea_round, purely combinational, one cycle, encrypt/decrypt (and XTEA) selectable. It is instantiated CYCLES_PER_CLK times in a generate chain.

Test Plan:
- Encrypt, key = 0, block = 0, defaults -> o_block = 64'h41EA3A0A_94BAA940, o_valid exactly 32 clocks after accept.
- Decrypt of 64'h41EA3A0A_94BAA940 with key = 0 -> 64'h0. Then 100 random key/block pairs, encrypt then decrypt -> original block.
- CYCLES_PER_CLK = 4 -> same vectors, latency 8 clocks. NUM_CYCLES = 16 -> encrypt/decrypt round-trip passes.
- Hold i_ready low 10 clocks in DONE -> o_block stable, o_ready = 0, a new i_valid is ignored. Raise i_ready -> o_ready = 1 the next clock.
- i_clear at RUN clock 5 -> IDLE next clock, no o_valid. Async i_rst_n low mid-RUN -> all outputs at reset values immediately.
- With TEA_XTEA_EN, i_xtea = 1, key = 0, block = 0 -> 64'hDEE9D4D8_F7131ED9, and decrypt round-trips.
